// File: rtl/sc_phase_pkg.sv
// Shared state encoding and config clamp helpers for the two-phase SC clock generator.
// Pure types and functions, no latency or flow control of its own.
package sc_phase_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH1,
    ST_GAP12,
    ST_PH2,
    ST_GAP21
  } phase_state_t;

  localparam int unsigned MIN_GAP = 1;

  // phi1e must fall strictly before phi1, so a phase never gets shorter than early+1.
  function automatic int unsigned clamp_ph(input int unsigned value, input int unsigned early);
    return (value <= early) ? early + 1 : value;
  endfunction

endpackage

// File: rtl/sc_nonoverlap_ch.sv
// One channel's gate stage: masks the shared phase gates with the frame-latched enable.
// One register stage, no backpressure.
module sc_nonoverlap_ch (
  input  logic clk,
  input  logic rst,
  input  logic i_g_ph1,
  input  logic i_g_ph1e,
  input  logic i_g_ph2,
  input  logic i_ch_en,
  output logic o_phi1,
  output logic o_phi1e,
  output logic o_phi2
);

  logic r_phi1;
  logic r_phi1e;
  logic r_phi2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phi1  <= 1'b0;
      r_phi1e <= 1'b0;
      r_phi2  <= 1'b0;
    end else begin
      r_phi1  <= i_g_ph1  & i_ch_en;
      r_phi1e <= i_g_ph1e & i_ch_en;
      r_phi2  <= i_g_ph2  & i_ch_en;
    end
  end

  assign o_phi1  = r_phi1;
  assign o_phi1e = r_phi1e;
  assign o_phi2  = r_phi2;

endmodule

// File: rtl/sc_phase_gen.sv
// Non-overlapping phi1/phi1e/phi2 generator; outputs registered from next-state, so PH1 entry shows one edge after en.
// Config is accepted only in IDLE or on the last GAP21 cycle; an offer at any other time simply waits.
module sc_phase_gen
  import sc_phase_pkg::*;
#(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_PH  = 8,
  parameter int unsigned DEF_GAP = 2,
  parameter int unsigned EARLY   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_ph,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [N_CH-1:0]  ch_en,
  output logic [N_CH-1:0]  phi1,
  output logic [N_CH-1:0]  phi1e,
  output logic [N_CH-1:0]  phi2,
  output logic             frame_strobe,
  output logic             busy
);

  phase_state_t     r_state;
  phase_state_t     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_ph;
  logic [CNT_W-1:0] r_gap;
  logic [N_CH-1:0]  r_ch_en;
  logic [N_CH-1:0]  w_ch_en_nxt;
  logic             r_cfg_ready;
  logic             r_frame_strobe;
  logic             r_busy;

  logic             w_accept;
  logic [CNT_W-1:0] w_ph_clamped;
  logic [CNT_W-1:0] w_gap_clamped;
  logic [CNT_W-1:0] w_ph_eff;
  logic [CNT_W-1:0] w_gap_eff;
  logic             w_enter_ph1;
  logic             w_g_ph1;
  logic             w_g_ph1e;
  logic             w_g_ph2;
  logic             w_cfg_ready_nxt;

  assign w_accept      = cfg_valid & r_cfg_ready;
  assign w_ph_clamped  = CNT_W'(clamp_ph(32'(cfg_ph), EARLY));
  assign w_gap_clamped = (cfg_gap == '0) ? CNT_W'(MIN_GAP) : cfg_gap;
  // An accept coinciding with PH1 entry must already govern that frame's counter loads.
  assign w_ph_eff      = w_accept ? w_ph_clamped  : r_ph;
  assign w_gap_eff     = w_accept ? w_gap_clamped : r_gap;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (en) begin
          w_state_nxt = ST_PH1;
          w_cnt_nxt   = w_ph_eff - CNT_W'(1);
        end
      end
      ST_PH1: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_GAP12;
          w_cnt_nxt   = w_gap_eff - CNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_GAP12: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_PH2;
          w_cnt_nxt   = w_ph_eff - CNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_PH2: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_GAP21;
          w_cnt_nxt   = w_gap_eff - CNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_GAP21: begin
        if (r_cnt == '0) begin
          if (en) begin
            w_state_nxt = ST_PH1;
            w_cnt_nxt   = w_ph_eff - CNT_W'(1);
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Gates are decoded from the next state/count so the output flops line up with the state flop.
  assign w_enter_ph1     = (w_state_nxt == ST_PH1) && (r_state != ST_PH1);
  assign w_g_ph1         = (w_state_nxt == ST_PH1);
  assign w_g_ph1e        = (w_state_nxt == ST_PH1) && (w_cnt_nxt >= CNT_W'(EARLY));
  assign w_g_ph2         = (w_state_nxt == ST_PH2);
  assign w_cfg_ready_nxt = (w_state_nxt == ST_IDLE) ||
                           ((w_state_nxt == ST_GAP21) && (w_cnt_nxt == '0));
  assign w_ch_en_nxt     = w_enter_ph1 ? ch_en : r_ch_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_ph           <= CNT_W'(DEF_PH);
      r_gap          <= CNT_W'(DEF_GAP);
      r_ch_en        <= '0;
      r_cfg_ready    <= 1'b1;
      r_frame_strobe <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      if (w_accept) begin
        r_ph  <= w_ph_clamped;
        r_gap <= w_gap_clamped;
      end
      r_ch_en        <= w_ch_en_nxt;
      r_cfg_ready    <= w_cfg_ready_nxt;
      r_frame_strobe <= w_enter_ph1;
      r_busy         <= (w_state_nxt != ST_IDLE);
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    sc_nonoverlap_ch u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_g_ph1 (w_g_ph1),
      .i_g_ph1e(w_g_ph1e),
      .i_g_ph2 (w_g_ph2),
      .i_ch_en (w_ch_en_nxt[gi]),
      .o_phi1  (phi1[gi]),
      .o_phi1e (phi1e[gi]),
      .o_phi2  (phi2[gi])
    );
  end

  assign cfg_ready    = r_cfg_ready;
  assign frame_strobe = r_frame_strobe;
  assign busy         = r_busy;

endmodule

// File: tb/tb_sc_phase_gen.sv
// Bench for sc_phase_gen: per-cycle expected outputs are queued from frame timing formulas
// and popped by a negedge monitor; each scenario task adds its own spot checks.
module tb_sc_phase_gen;
  localparam int N_CH  = 2;
  localparam int CNT_W = 8;
  localparam int EARLY = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_ph;
  logic [CNT_W-1:0] cfg_gap;
  logic [N_CH-1:0]  ch_en;
  logic [N_CH-1:0]  phi1;
  logic [N_CH-1:0]  phi1e;
  logic [N_CH-1:0]  phi2;
  logic             frame_strobe;
  logic             busy;

  typedef struct packed {
    logic [1:0] phi1;
    logic [1:0] phi1e;
    logic [1:0] phi2;
    logic       strobe;
    logic       busy;
    logic       ready;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_obs;
  obs_t mon_exp;
  int   checks = 0;
  int   errors = 0;
  bit   sb_en  = 1'b0;

  always #5 clk = ~clk;

  sc_phase_gen #(
    .N_CH   (N_CH),
    .CNT_W  (CNT_W),
    .DEF_PH (8),
    .DEF_GAP(2),
    .EARLY  (EARLY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ph      (cfg_ph),
    .cfg_gap     (cfg_gap),
    .ch_en       (ch_en),
    .phi1        (phi1),
    .phi1e       (phi1e),
    .phi2        (phi2),
    .frame_strobe(frame_strobe),
    .busy        (busy)
  );

  // Scoreboard monitor: one expected entry per clock, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb_en) begin
      mon_obs = {phi1, phi1e, phi2, frame_strobe, busy, cfg_ready};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow at %0t: got %b with no expected entry", $time, mon_obs);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs !== mon_exp) begin
          errors++;
          $display("FAIL sb_cycle at %0t: got %b required %b (phi1 phi1e phi2 strobe busy ready)",
                   $time, mon_obs, mon_exp);
        end
      end
      checks++;
      if (((phi1 & phi2) !== 2'b00) || ((phi1e & ~phi1) !== 2'b00)) begin
        errors++;
        $display("FAIL invariant at %0t: phi1=%b phi1e=%b phi2=%b required no overlap", $time, phi1, phi1e, phi2);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Expected outputs for one frame of width w, gap g; len=0 pushes the whole period.
  task automatic push_frame(input int w, input int g, input logic [1:0] chen, input int len);
    obs_t e;
    int   p;
    int   n;
    p = 2 * w + 2 * g;
    n = (len == 0) ? p : len;
    for (int k = 0; k < n; k++) begin
      e.phi1   = (k < w) ? chen : 2'b00;
      e.phi1e  = (k < w - EARLY) ? chen : 2'b00;
      e.phi2   = (k >= w + g && k < 2 * w + g) ? chen : 2'b00;
      e.strobe = (k == 0);
      e.busy   = 1'b1;
      e.ready  = (k == p - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_idle(input int n);
    obs_t e;
    e = '0;
    e.ready = 1'b1;
    for (int k = 0; k < n; k++) exp_q.push_back(e);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_ph = '0; cfg_gap = '0; ch_en = '0;
    step(3);
    checks++; if (phi1 !== 2'b00)  begin errors++; $display("FAIL reset_phi1: got %b required 00", phi1); end
    checks++; if (phi1e !== 2'b00) begin errors++; $display("FAIL reset_phi1e: got %b required 00", phi1e); end
    checks++; if (phi2 !== 2'b00)  begin errors++; $display("FAIL reset_phi2: got %b required 00", phi2); end
    checks++; if (frame_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b required 0", frame_strobe); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b required 1", cfg_ready); end
    rst = 1'b0;
    step(1);
    sb_en = 1'b1;
  endtask

  task automatic test_defaults;
    ch_en = 2'b11; en = 1'b1;
    push_frame(8, 2, 2'b11, 0);
    push_frame(8, 2, 2'b11, 0);
    push_idle(2);
    step(21);
    checks++; if (frame_strobe !== 1'b1) begin errors++; $display("FAIL defaults_period: strobe %b at cycle 20 required 1", frame_strobe); end
    en = 1'b0;
    step(21);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL defaults_drain: %0d entries left required 0", exp_q.size()); end
  endtask

  task automatic test_en_drop;
    en = 1'b1;
    push_frame(8, 2, 2'b11, 0);
    push_idle(3);
    step(3);
    en = 1'b0;
    step(20);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_drop_busy: got %b required 0", busy); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL en_drop_drain: %0d entries left required 0", exp_q.size()); end
  endtask

  task automatic test_chen;
    ch_en = 2'b11; en = 1'b1;
    push_frame(8, 2, 2'b11, 0);
    push_frame(8, 2, 2'b01, 0);
    push_idle(2);
    step(12);
    ch_en = 2'b01;
    checks++; if (phi2 !== 2'b11) begin errors++; $display("FAIL chen_ph2: got %b required 11", phi2); end
    step(9);
    en = 1'b0;
    step(21);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL chen_drain: %0d entries left required 0", exp_q.size()); end
  endtask

  task automatic test_cfg_midframe;
    ch_en = 2'b11; en = 1'b1;
    push_frame(8, 2, 2'b11, 0);
    push_frame(4, 3, 2'b11, 0);
    push_idle(2);
    step(12);
    cfg_valid = 1'b1; cfg_ph = 8'd4; cfg_gap = 8'd3;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_mid_ready: got %b required 0", cfg_ready); end
    step(9);
    checks++; if (frame_strobe !== 1'b1) begin errors++; $display("FAIL cfg_mid_inflight: strobe %b at cycle 20 required 1", frame_strobe); end
    cfg_valid = 1'b0; en = 1'b0;
    step(15);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL cfg_mid_drain: %0d entries left required 0", exp_q.size()); end
  endtask

  task automatic test_cfg_clamp;
    ch_en = 2'b11; en = 1'b1;
    cfg_valid = 1'b1; cfg_ph = 8'd1; cfg_gap = 8'd0;
    push_frame(2, 1, 2'b11, 0);
    push_frame(2, 1, 2'b11, 0);
    push_idle(2);
    step(1);
    cfg_valid = 1'b0;
    checks++; if (phi1e !== 2'b11) begin errors++; $display("FAIL clamp_phi1e: got %b required 11", phi1e); end
    step(6);
    checks++; if (frame_strobe !== 1'b1) begin errors++; $display("FAIL clamp_period: strobe %b at cycle 6 required 1", frame_strobe); end
    en = 1'b0;
    step(7);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL clamp_drain: %0d entries left required 0", exp_q.size()); end
  endtask

  task automatic test_rst_midframe;
    ch_en = 2'b11; en = 1'b1;
    push_frame(2, 1, 2'b11, 4);
    push_idle(1);
    push_frame(8, 2, 2'b11, 0);
    push_frame(8, 2, 2'b11, 0);
    push_idle(2);
    step(4);
    checks++; if (phi2 !== 2'b11) begin errors++; $display("FAIL rst_pre_ph2: got %b required 11", phi2); end
    rst = 1'b1;
    step(1);
    checks++; if ((phi1 | phi1e | phi2) !== 2'b00) begin errors++; $display("FAIL rst_gates: got %b required 00", phi1 | phi1e | phi2); end
    rst = 1'b0;
    step(21);
    checks++; if (frame_strobe !== 1'b1) begin errors++; $display("FAIL rst_restart_period: strobe %b at cycle 20 required 1", frame_strobe); end
    en = 1'b0;
    step(21);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_drain: %0d entries left required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_en_drop();
    test_chen();
    test_cfg_midframe();
    test_cfg_clamp();
    test_rst_midframe();
    sb_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_phase_gen.md
Name: sc_phase_gen

Overview:
- Parametrised non-overlapping two-phase clock generator for the switched-capacitor filter array.
- Drives the phi1 and phi2 switch gates on N_CH filter channels.
- Drives an early-phi1 (phi1e) gate for bottom-plate sampling on each channel.
- Phase width and dead time are runtime-programmable through a valid/ready config port. Config and channel enables take effect only at a frame boundary, so a phase is never truncated.

Parameters:
- N_CH, 2, number of filter channels driven.
- CNT_W, 8, width of the phase-width and gap counters and config fields.
- DEF_PH, 8, phase width in clk cycles after reset.
- DEF_GAP, 2, non-overlap gap in clk cycles after reset.
- EARLY, 1, number of cycles phi1e falls before phi1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  run request.
- cfg_valid  input  1  config offer.
- cfg_ready  output  1  config can be accepted this cycle.
- cfg_ph  input  CNT_W  requested phase width.
- cfg_gap  input  CNT_W  requested gap width.
- ch_en  input  N_CH  per-channel enable.
- phi1  output  N_CH  phase-1 switch gate.
- phi1e  output  N_CH  early phase-1 gate.
- phi2  output  N_CH  phase-2 switch gate.
- frame_strobe  output  1  one-cycle pulse on the first cycle of PH1.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset values:
  - phi1, phi1e, phi2 = 0.
  - frame_strobe = 0, busy = 0, cfg_ready = 1.
  - State = IDLE.
  - ph_q = DEF_PH, gap_q = DEF_GAP, ch_en_q = 0.
- rst asserted mid-frame: all gates go low on the next edge with no completion of the current phase. Config returns to defaults.
- FSM states: IDLE, PH1, GAP12, PH2, GAP21. A down-counter is loaded on each state entry.
- IDLE: all gates low. If en=1 is sampled in IDLE at cycle t, PH1 is entered at t+1 and frame_strobe=1 at t+1.
- Frame timing, with t0 as the frame_strobe cycle, W = ph_q and G = gap_q:
  - phi1 high over t0 .. t0+W-1.
  - phi1e high over t0 .. t0+W-1-EARLY.
  - GAP12 low over t0+W .. t0+W+G-1.
  - phi2 high over t0+W+G .. t0+2W+G-1.
  - GAP21 low over t0+2W+G .. t0+2W+2G-1.
  - Period is 2W+2G cycles.
- On the last GAP21 cycle: if en=1, go to PH1 and start the next frame without a bubble. If en=0, go to IDLE.
- en deassertion mid-frame: the frame completes through GAP21, then IDLE.
- Invariant: phi1 and phi2 are never high in the same cycle on any channel. phi1e is never high when phi1 is low.
- Per-channel gating: gate[i] = state gate AND ch_en_q[i]. ch_en is sampled into ch_en_q on the edge that enters PH1. A change to ch_en mid-frame has no effect until the next frame.
- Config handshake:
  - cfg_ready = 1 in IDLE and on the last GAP21 cycle; 0 otherwise.
  - Accepted when cfg_valid && cfg_ready.
  - The new values govern the frame starting on the next PH1 entry, including a back-to-back frame.
  - cfg_valid with cfg_ready=0 is ignored. The holder keeps the config offered.
- Clamping on accept:
  - cfg_ph ≤ EARLY → ph_q = EARLY+1.
  - cfg_gap = 0 → gap_q = 1.
  - Maximum values of 2^CNT_W-1 are legal with no wrap. The counters load W-1 and G-1.
- Simultaneous events:
  - rst has priority over everything.
  - A config accept and the PH1 entry in the same cycle use the new config.
- busy = (state != IDLE).

Decomposition:
- Package sc_phase_pkg holds:
  - the state enum typedef phase_state_t;
  - the clamp constants MIN_GAP=1;
  - a function clamp_ph(value, EARLY).
- Sub-module sc_nonoverlap_ch: per-channel gating and output register for phi1, phi1e and phi2.
  - Inputs: the three state gates, ch_en_q bit, clk, rst.
  - Instantiated N_CH times by generate.

Test Plan:
- Defaults (W=8, G=2, EARLY=1), ch_en=2'b11, en held high:
  - frame_strobe every 20 cycles.
  - phi1 high 8 cycles, phi1e high 7 cycles.
  - 2 low cycles, phi2 high 8 cycles, 2 low cycles.
  - No phi1 and phi2 overlap on any cycle.
- Config cfg_ph=4, cfg_gap=3 offered mid-PH2:
  - Accepted on the last GAP21 cycle.
  - Next frame has period 14 with phi1 high for 4 cycles.
  - Frame in flight is unchanged.
- Config cfg_ph=1, cfg_gap=0 offered in IDLE:
  - Clamped to W=2, G=1, period 6.
  - phi1e high for 1 cycle.
- en dropped at cycle 3 of PH1:
  - Frame finishes through GAP21, then IDLE.
  - busy falls on the cycle after GAP21 ends.
  - No further frame_strobe.
- ch_en changed 11→01 during PH2:
  - Channel 1 keeps toggling until the frame ends.
  - From the next frame_strobe onward, channel 1 gates stay 0.
- rst pulsed for 1 cycle during PH2:
  - All gates are 0 the next cycle.
  - Config returns to W=8, G=2.
  - Restart with en=1 gives a 20-cycle period.
